z80_comm_latch: RTL

Bidirectional command/reply mailbox between the 68K and the Z80 sound CPU, the 68K-side counterpart to the Z80 port decoder that produces the nSDZ80R/nSDZ80W/nSDZ80CLR strobes. The 68K posts a command byte, which raises a Z80 NMI. The Z80 reads the command and posts a reply byte, which the 68K reads back. All asynchronous bus strobes are synchronized to CLK_24M. NMI generation is a small FSM that guarantees a fresh falling edge per command.

---
 rtl/z80_comm_latch_if.sv | 39 +++
 rtl/z80_comm_latch.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/z80_comm_latch_if.sv
// 68K / Z80 mailbox bus bundle: strobes and data on both CPU sides.
// master drives the CPU-side pins, slave is the latch itself.
interface z80_comm_latch_if;
    logic       nSDW;
    logic [7:0] M68K_DATA_IN;
    logic       nSDRD68;
    logic [7:0] M68K_DATA_OUT;
    logic       M68K_DATA_OE;
    logic       nSDZ80R;
    logic       nSDZ80W;
    logic       nSDZ80CLR;
    logic       nNMIEN;
    logic       nNMIDIS;
    logic [7:0] SDD_IN;
    logic [7:0] SDD_OUT;
    logic       SDD_OE;
    logic       nZ80NMI;
    logic       CMD_PENDING;
    logic       REPLY_VALID;
    logic       CMD_OVERRUN;

    modport master (
        output nSDW, M68K_DATA_IN, nSDRD68,
        output nSDZ80R, nSDZ80W, nSDZ80CLR,
        output nNMIEN, nNMIDIS, SDD_IN,
        input  M68K_DATA_OUT, M68K_DATA_OE,
        input  SDD_OUT, SDD_OE, nZ80NMI,
        input  CMD_PENDING, REPLY_VALID, CMD_OVERRUN
    );

    modport slave (
        input  nSDW, M68K_DATA_IN, nSDRD68,
        input  nSDZ80R, nSDZ80W, nSDZ80CLR,
        input  nNMIEN, nNMIDIS, SDD_IN,
        output M68K_DATA_OUT, M68K_DATA_OE,
        output SDD_OUT, SDD_OE, nZ80NMI,
        output CMD_PENDING, REPLY_VALID, CMD_OVERRUN
    );
endinterface

// File: rtl/z80_comm_latch.sv
// 68K <-> Z80 command/reply mailbox with synchronized strobes
// and an NMI FSM that guarantees a fresh NMI edge per command.
module z80_comm_latch #(
    parameter int GAP_CYCLES = 4
) (
    input logic              CLK_24M,
    input logic              RESET,
    z80_comm_latch_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} nmi_state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    localparam int SW   = 0;
    localparam int SRD  = 1;
    localparam int ZR   = 2;
    localparam int ZW   = 3;
    localparam int ZCLR = 4;
    localparam int NEN  = 5;
    localparam int NDIS = 6;

    logic [6:0] pins;
    logic [6:0] s1, s2, s3;
    logic [6:0] fall, rise;
    logic [1:0] settle;
    logic       armed;

    logic [7:0] d68, dz80;
    logic [7:0] cmd, reply;
    logic       cmd_pending, reply_valid, cmd_overrun;
    logic       nmi_en, nmi_n;

    nmi_state_t state, state_n;
    logic [3:0] gap_cnt, gap_n;

    logic wr_edge, clr_edge;

    assign pins = {bus.nNMIDIS, bus.nNMIEN, bus.nSDZ80CLR,
                   bus.nSDZ80W, bus.nSDZ80R, bus.nSDRD68,
                   bus.nSDW};

    // Strobes held low across reset release would look like a fresh
    // falling edge once the chain drains; blank edges until it settles.
    assign armed = (settle == 2'd3);
    assign fall  = s3 & ~s2 & {7{armed}};
    assign rise  = ~s3 & s2 & {7{armed}};

    assign wr_edge  = fall[SW];
    assign clr_edge = rise[ZR] | fall[ZCLR];

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            s1     <= '1;
            s2     <= '1;
            s3     <= '1;
            settle <= 2'd0;
            d68    <= 8'h00;
            dz80   <= 8'h00;
        end else begin
            s1     <= pins;
            s2     <= s1;
            s3     <= s2;
            d68    <= bus.M68K_DATA_IN;
            dz80   <= bus.SDD_IN;
            if (!armed)
                settle <= settle + 2'd1;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            cmd         <= 8'h00;
            reply       <= 8'h00;
            cmd_pending <= 1'b0;
            reply_valid <= 1'b0;
            cmd_overrun <= 1'b0;
            nmi_en      <= 1'b0;
        end else begin
            // A write racing a clear wins and is not an overrun.
            if (wr_edge) begin
                cmd         <= d68;
                cmd_pending <= 1'b1;
                if (cmd_pending && !clr_edge)
                    cmd_overrun <= 1'b1;
            end else if (clr_edge) begin
                cmd_pending <= 1'b0;
            end

            if (fall[ZW]) begin
                reply       <= dz80;
                reply_valid <= 1'b1;
            end else if (rise[SRD]) begin
                reply_valid <= 1'b0;
            end

            if (fall[NDIS])
                nmi_en <= 1'b0;
            else if (fall[NEN])
                nmi_en <= 1'b1;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            state   <= IDLE;
            gap_cnt <= 4'd0;
            nmi_n   <= 1'b1;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            nmi_n   <= (state_n != ACTIVE);
        end
    end

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        unique case (state)
            IDLE: begin
                if (cmd_pending && nmi_en)
                    state_n = ACTIVE;
            end
            ACTIVE: begin
                if (clr_edge || wr_edge || !nmi_en) begin
                    state_n = GAP;
                    gap_n   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0)
                    state_n = IDLE;
                else
                    gap_n = gap_cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.SDD_OUT       = cmd;
    assign bus.SDD_OE        = ~bus.nSDZ80R;
    assign bus.M68K_DATA_OUT = reply;
    assign bus.M68K_DATA_OE  = ~bus.nSDRD68;
    assign bus.nZ80NMI       = nmi_n;
    assign bus.CMD_PENDING   = cmd_pending;
    assign bus.REPLY_VALID   = reply_valid;
    assign bus.CMD_OVERRUN   = cmd_overrun;
endmodule
